// File: rtl/fetch_pipelined.sv
// Pipelined instruction fetch stage: credit-based request issue, in-order PC tracking,
// an instruction buffer toward the decoder, and redirect handling that discards stale responses.
module fetch_pipelined #(
    parameter int              XLEN            = 32,
    parameter logic [XLEN-1:0] BOOT_ADDR       = '0,
    parameter int              MAX_OUTSTANDING = 2,
    parameter int              IBUF_DEPTH      = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               fetch_addr_ready,
    output logic               fetch_addr_valid,
    output logic [XLEN-1:0]    fetch_addr,
    input  logic               fetch_data_valid,
    input  logic [31:0]        fetch_data,
    output logic               fetch_data_ready,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic [XLEN+31:0]   fetch_o,
    output logic               fetch_o_valid,
    input  logic               fetch_o_ready
);

    localparam int KW = $clog2(MAX_OUTSTANDING + 1);
    localparam int CW = $clog2(IBUF_DEPTH + 1);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int BW = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;

    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  pcf_mem [MAX_OUTSTANDING];
    logic [PW-1:0]    pcf_rd;
    logic [PW-1:0]    pcf_wr;
    logic [KW-1:0]    inflight;
    logic [KW-1:0]    kill_cnt;

    logic [XLEN+31:0] ibuf_mem [IBUF_DEPTH];
    logic [BW-1:0]    ibuf_rd;
    logic [BW-1:0]    ibuf_wr;
    logic [CW-1:0]    ibuf_cnt;

    logic issue;
    logic resp;
    logic ibuf_push;
    logic ibuf_pop;

    function automatic logic [PW-1:0] pcf_next(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [BW-1:0] ibuf_next(input logic [BW-1:0] p);
        return (p == BW'(IBUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Counting in-flight requests against buffer space means every response has a slot waiting.
    always_comb begin
        fetch_addr_valid = rstn && !redirect_valid
                           && (int'(inflight) < MAX_OUTSTANDING)
                           && (int'(inflight) + int'(ibuf_cnt) < IBUF_DEPTH);
        fetch_addr       = pc_q;
        fetch_data_ready = 1'b1;
        issue            = fetch_addr_valid && fetch_addr_ready;
        resp             = fetch_data_valid && (inflight != '0);
        ibuf_push        = resp && (kill_cnt == '0) && !redirect_valid;
        fetch_o_valid    = (ibuf_cnt != '0) && !redirect_valid;
        fetch_o          = (ibuf_cnt != '0) ? ibuf_mem[ibuf_rd] : '0;
        ibuf_pop         = fetch_o_valid && fetch_o_ready;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_q     <= BOOT_ADDR;
            pcf_rd   <= '0;
            pcf_wr   <= '0;
            inflight <= '0;
            kill_cnt <= '0;
        end else begin
            if (redirect_valid) begin
                pc_q <= redirect_pc & ~XLEN'(3);
            end else if (issue) begin
                pc_q <= pc_q + XLEN'(4);
            end
            if (issue) begin
                pcf_wr <= pcf_next(pcf_wr);
            end
            if (resp) begin
                pcf_rd <= pcf_next(pcf_rd);
            end
            inflight <= inflight + KW'(issue) - KW'(resp);
            // Everything still outstanding after this edge belongs to the old path.
            if (redirect_valid) begin
                kill_cnt <= inflight - KW'(resp);
            end else if (resp && (kill_cnt != '0)) begin
                kill_cnt <= kill_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (issue) begin
            pcf_mem[pcf_wr] <= pc_q;
        end
        if (ibuf_push) begin
            ibuf_mem[ibuf_wr] <= {pcf_mem[pcf_rd], fetch_data};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ibuf_rd  <= '0;
            ibuf_wr  <= '0;
            ibuf_cnt <= '0;
        end else if (redirect_valid) begin
            ibuf_rd  <= '0;
            ibuf_wr  <= '0;
            ibuf_cnt <= '0;
        end else begin
            if (ibuf_push) begin
                ibuf_wr <= ibuf_next(ibuf_wr);
            end
            if (ibuf_pop) begin
                ibuf_rd <= ibuf_next(ibuf_rd);
            end
            ibuf_cnt <= ibuf_cnt + CW'(ibuf_push) - CW'(ibuf_pop);
        end
    end

    resp_without_request: assert property (
        @(posedge clk) disable iff (!rstn) !(fetch_data_valid && (inflight == '0))
    );

endmodule

// File: tb/tb_fetch_pipelined.sv
// Directed bench for fetch_pipelined: an in-order cache model with configurable latency
// feeds the DUT while every request address and every decoder-bound entry is compared.
module tb_fetch_pipelined;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        fetch_addr_ready = 1'b1;
    logic        fetch_addr_valid;
    logic [31:0] fetch_addr;
    logic        fetch_data_valid = 1'b0;
    logic [31:0] fetch_data = '0;
    logic        fetch_data_ready;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [63:0] fetch_o;
    logic        fetch_o_valid;
    logic        fetch_o_ready = 1'b1;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        cq[$];
    int          cyc;
    int          lat_min;
    int          lat_max;
    int          last_due;
    logic [31:0] exp_pc;
    logic [31:0] exp_req;
    int          npops;
    int          nissue;
    int          max_inflight;
    logic        have_first;
    logic [31:0] first_pc;
    int          checks = 0;
    int          passed = 0;

    fetch_pipelined #(
        .XLEN(32),
        .BOOT_ADDR(32'h0000_1000),
        .MAX_OUTSTANDING(2),
        .IBUF_DEPTH(4)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .fetch_addr_ready(fetch_addr_ready),
        .fetch_addr_valid(fetch_addr_valid),
        .fetch_addr(fetch_addr),
        .fetch_data_valid(fetch_data_valid),
        .fetch_data(fetch_data),
        .fetch_data_ready(fetch_data_ready),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .fetch_o(fetch_o),
        .fetch_o_valid(fetch_o_valid),
        .fetch_o_ready(fetch_o_ready)
    );

    always #5 clk = ~clk;

    // One clock of traffic: present a cache response, observe handshakes, advance past the edge.
    task automatic tick();
        int d;
        if (cq.size() > 0 && cq[0].due <= cyc) begin
            fetch_data_valid = 1'b1;
            fetch_data       = ~cq[0].addr;
        end else begin
            fetch_data_valid = 1'b0;
            fetch_data       = '0;
        end
        #1;
        if (fetch_o_valid && fetch_o_ready) begin
            checks++;
            if (fetch_o !== {exp_pc, ~exp_pc}) begin
                $display("[TB] FAIL fetch_o: got pc=%h data=%h, expected pc=%h data=%h",
                         fetch_o[63:32], fetch_o[31:0], exp_pc, ~exp_pc);
            end else begin
                passed++;
            end
            if (!have_first) begin
                first_pc   = fetch_o[63:32];
                have_first = 1'b1;
            end
            exp_pc = exp_pc + 32'd4;
            npops++;
        end
        if (fetch_addr_valid && fetch_addr_ready) begin
            checks++;
            if (fetch_addr !== exp_req) begin
                $display("[TB] FAIL fetch_addr: got %h expected %h", fetch_addr, exp_req);
            end else begin
                passed++;
            end
            d = cyc + $urandom_range(lat_max, lat_min);
            if (d < last_due) d = last_due;
            last_due = d;
            cq.push_back('{addr: fetch_addr, due: d});
            exp_req = exp_req + 32'd4;
            nissue++;
        end
        if (fetch_data_valid) void'(cq.pop_front());
        if (redirect_valid) begin
            exp_pc     = redirect_pc & ~32'h3;
            exp_req    = redirect_pc & ~32'h3;
            have_first = 1'b0;
        end
        if (cq.size() > max_inflight) max_inflight = cq.size();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rstn             = 1'b0;
        fetch_addr_ready = 1'b1;
        fetch_o_ready    = 1'b1;
        redirect_valid   = 1'b0;
        redirect_pc      = '0;
        fetch_data_valid = 1'b0;
        fetch_data       = '0;
        cq.delete();
        exp_pc       = 32'h1000;
        exp_req      = 32'h1000;
        last_due     = 0;
        npops        = 0;
        nissue       = 0;
        max_inflight = 0;
        have_first   = 1'b0;
        lat_min      = 1;
        lat_max      = 1;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        cyc  = 0;
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        #1;
        checks++;
        if (fetch_addr_valid !== 1'b0) $display("[TB] FAIL reset_addr_valid: got %b expected 0", fetch_addr_valid);
        else passed++;
        checks++;
        if (fetch_o_valid !== 1'b0) $display("[TB] FAIL reset_o_valid: got %b expected 0", fetch_o_valid);
        else passed++;
        checks++;
        if (fetch_o !== 64'h0) $display("[TB] FAIL reset_fetch_o: got %h expected 0", fetch_o);
        else passed++;
        checks++;
        if (fetch_data_ready !== 1'b1) $display("[TB] FAIL reset_data_ready: got %b expected 1", fetch_data_ready);
        else passed++;
        do_reset();
        checks++;
        if (fetch_addr_valid !== 1'b1 || fetch_addr !== 32'h1000)
            $display("[TB] FAIL boot_request: got valid=%b addr=%h expected valid=1 addr=00001000",
                     fetch_addr_valid, fetch_addr);
        else passed++;
    endtask

    task automatic test_stream();
        do_reset();
        repeat (20) tick();
        checks++;
        if (nissue != 20) $display("[TB] FAIL stream_issues: got %0d expected 20", nissue);
        else passed++;
        checks++;
        if (npops != 18) $display("[TB] FAIL stream_pops: got %0d expected 18", npops);
        else passed++;
    endtask

    task automatic test_stall();
        do_reset();
        fetch_o_ready = 1'b0;
        repeat (10) tick();
        checks++;
        if (nissue != 4) $display("[TB] FAIL stall_issues: got %0d expected 4", nissue);
        else passed++;
        checks++;
        if (fetch_addr_valid !== 1'b0) $display("[TB] FAIL stall_addr_valid: got %b expected 0", fetch_addr_valid);
        else passed++;
        checks++;
        if (fetch_o_valid !== 1'b1 || fetch_o[63:32] !== 32'h1000)
            $display("[TB] FAIL stall_head: got valid=%b pc=%h expected valid=1 pc=00001000",
                     fetch_o_valid, fetch_o[63:32]);
        else passed++;
        fetch_o_ready = 1'b1;
        repeat (12) tick();
        checks++;
        if (npops < 4 || nissue <= 4)
            $display("[TB] FAIL stall_resume: got pops=%0d issues=%0d expected pops>=4 issues>4", npops, nissue);
        else passed++;
    endtask

    task automatic test_redirect_latency();
        do_reset();
        lat_min = 3;
        lat_max = 3;
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h2002;
        #1;
        checks++;
        if (fetch_addr_valid !== 1'b0 || fetch_o_valid !== 1'b0)
            $display("[TB] FAIL redirect_block: got addr_valid=%b o_valid=%b expected 0/0",
                     fetch_addr_valid, fetch_o_valid);
        else passed++;
        tick();
        redirect_valid = 1'b0;
        repeat (15) tick();
        checks++;
        if (!have_first || first_pc !== 32'h2000)
            $display("[TB] FAIL redirect_first_pc: got seen=%b pc=%h expected pc=00002000", have_first, first_pc);
        else passed++;
    endtask

    task automatic test_redirect_collision();
        do_reset();
        lat_min = 2;
        lat_max = 2;
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3000;
        tick();
        redirect_valid = 1'b0;
        repeat (15) tick();
        checks++;
        if (!have_first || first_pc !== 32'h3000)
            $display("[TB] FAIL collision_first_pc: got seen=%b pc=%h expected pc=00003000", have_first, first_pc);
        else passed++;
    endtask

    task automatic test_random();
        int guard;
        do_reset();
        lat_min = 1;
        lat_max = 3;
        guard   = 0;
        while (npops < 1000 && guard < 20000) begin
            fetch_addr_ready = 1'($urandom_range(1, 0));
            fetch_o_ready    = 1'($urandom_range(1, 0));
            tick();
            guard++;
        end
        fetch_addr_ready = 1'b1;
        fetch_o_ready    = 1'b1;
        checks++;
        if (npops != 1000) $display("[TB] FAIL random_count: got %0d expected 1000", npops);
        else passed++;
        checks++;
        if (max_inflight > 2) $display("[TB] FAIL random_inflight: got %0d expected <=2", max_inflight);
        else passed++;
    endtask

    task automatic test_async_reset();
        do_reset();
        repeat (8) tick();
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if (fetch_addr_valid !== 1'b0 || fetch_o_valid !== 1'b0 || fetch_o !== 64'h0)
            $display("[TB] FAIL async_reset: got addr_valid=%b o_valid=%b fetch_o=%h expected 0/0/0",
                     fetch_addr_valid, fetch_o_valid, fetch_o);
        else passed++;
        do_reset();
        repeat (10) tick();
        checks++;
        if (nissue != 10 || npops != 8)
            $display("[TB] FAIL restart: got issues=%0d pops=%0d expected 10/8", nissue, npops);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_latency();
        test_redirect_collision();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/fetch_pipelined.md
Name: fetch_pipelined

Overview:
- Next-generation instruction fetch stage. Sits between the PC and the instruction cache on one side and the decoder on the other.
- Keeps up to MAX_OUTSTANDING cache requests in flight, tracking their PCs in order.
- Buffers returned instructions in an IBUF_DEPTH-entry FIFO.
- Supports redirect (branch/exception): changes the PC, flushes the buffer and discards stale in-flight responses.

Parameters:
BOOT_ADDR, 0, PC value loaded at reset (XLEN bits, 4-byte aligned)
MAX_OUTSTANDING, 2, max cache requests issued but not yet answered (>=1)
IBUF_DEPTH, 4, instruction buffer entries (>=MAX_OUTSTANDING, power of 2)

Ports:
clk  in  1  clock
rstn  in  1  reset, asynchronous, active-low
fetch_addr_ready  in  1  cache can accept a request
fetch_addr_valid  out  1  request valid
fetch_addr  out  XLEN  request address
fetch_data_valid  in  1  cache response valid (in-order)
fetch_data  in  32  response instruction word
fetch_data_ready  out  1  response accepted
redirect_valid  in  1  redirect PC this cycle
redirect_pc  in  XLEN  new PC
fetch_o  out  XLEN+32  fetch_data_t {pc, data} to decoder
fetch_o_valid  out  1  fetch_o valid
fetch_o_ready  in  1  decoder accepts

Behaviour:
- Single clock clk. rstn is asynchronous, active-low.
- Reset values:
  - pc_q=BOOT_ADDR
  - inflight=0, kill_cnt=0, ibuf empty
  - fetch_addr_valid=0, fetch_o_valid=0, fetch_o=0
  - fetch_data_ready=1
- State:
  - pc_q: next PC to request.
  - PC tracking FIFO: depth MAX_OUTSTANDING.
  - inflight: entries in PC FIFO.
  - kill_cnt: number of oldest in-flight responses to discard. Width $clog2(MAX_OUTSTANDING+1).
  - ibuf: IBUF_DEPTH x {pc, data}. ibuf_cnt width $clog2(IBUF_DEPTH+1).
- Issue rule (credit-based):
  - fetch_addr_valid = !redirect_valid && inflight<MAX_OUTSTANDING && (inflight+ibuf_cnt)<IBUF_DEPTH.
  - fetch_addr = pc_q.
  - Accept when fetch_addr_valid && fetch_addr_ready. On accept: push pc_q into PC FIFO, pc_q <= pc_q+4 (XLEN wrap-around, no flag).
  - The credit rule guarantees a response always has buffer space, so fetch_data_ready is tied 1.
- Response rule:
  - On fetch_data_valid: pop the PC FIFO head.
  - If kill_cnt>0: discard the word, kill_cnt--.
  - Otherwise push {head_pc, fetch_data} into ibuf.
  - A response with inflight==0 is a protocol error: ignored, simulation assertion fires.
- Output:
  - fetch_o_valid = ibuf not empty && !redirect_valid.
  - fetch_o = ibuf head. Pop on fetch_o_valid && fetch_o_ready.
  - Registered: a response is visible on fetch_o no earlier than the next cycle (latency 1 cycle response->fetch_o_valid).
  - Push and pop in the same cycle are allowed, including when full (pop then push); ibuf_cnt is unchanged.
- Redirect (redirect_valid=1), all in the same edge:
  - pc_q <= {redirect_pc[XLEN-1:2], 2'b00}.
  - ibuf flushed (cnt=0). No issue or pop this cycle.
  - kill_cnt <= inflight after this cycle's response pop, i.e. inflight - (fetch_data_valid?1:0). This covers all requests still outstanding, including previously killed ones.
  - Back-to-back redirects: the last redirect wins; kill_cnt is recomputed each time.
- Ordering guarantee: every fetch_o entry has pc equal to the PC actually requested for that data. After a redirect, the first fetch_o.pc is the aligned redirect_pc.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). Cache responses arriving after reset deassertion for pre-reset requests are not supported; the cache shares the same reset.

Test Plan:
- Reset, BOOT_ADDR=0x1000, cache always ready, 1-cycle response, decoder always ready -> requests 0x1000, 0x1004, 0x1008...; fetch_o.pc follows the same sequence, one per cycle after fill, with data matching.
- Decoder ready held 0, MAX_OUTSTANDING=2, IBUF_DEPTH=4 -> exactly 4 requests issued, then fetch_addr_valid=0; ibuf full with pcs 0x1000-0x100C. Release ready -> drains in order; issue resumes.
- Cache latency 3 cycles, 2 requests in flight, redirect to 0x2002 -> pc_q=0x2000; both old responses discarded; first fetch_o.pc=0x2000.
- Redirect in the same cycle as a response with inflight=2 -> kill_cnt=1; only the next old response is dropped; no stale pc appears on fetch_o.
- fetch_addr_ready toggled randomly, decoder ready random, 1000 instructions -> fetch_o.pc strictly +4 per entry, no loss or duplication, inflight<=MAX_OUTSTANDING always.
- Assert rstn low mid-stream for 1 cycle asynchronously -> outputs zero immediately; after release, fetching restarts at BOOT_ADDR.
